t9990_blit_pixel_rmw: RTL and testbench

- Pixel access engine at the VRAM end of the blitter address path. It takes a 32-bit-word VRAM address plus the low X bits and colour mode, and performs the matching operation.
- Pixel read: reads the word, extracts the pixel and returns it right-aligned.
- Pixel write: read-modify-write of the word, merging a masked pixel into place.
- Sits between the blitter command sequencer and the VRAM arbiter port.

---
 rtl/t9990_blit_pixel_rmw_pkg.sv | 58 +++++
 rtl/t9990_blit_pixel_rmw_lane.sv | 35 +++
 rtl/t9990_blit_pixel_rmw.sv | 184 ++++++++++++++++++
 tb/tb_t9990_blit_pixel_rmw.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/t9990_blit_pixel_rmw_pkg.sv
// ---------------------------------------------------------------------------
// t9990_blit_pixel_rmw_pkg
// Shared definitions for the blitter pixel read / read-modify-write engine:
//   - CLRM_* colour-mode encodings (2/4/8/16 bpp)
//   - pixel engine state enum
//   - field_geom(): bit position (LSB) and right-aligned width mask of a
//     pixel inside a 32-bit little-endian VRAM word, from CLRM and X[3:0].
// ---------------------------------------------------------------------------
package t9990_blit_pixel_rmw_pkg;

    localparam logic [1:0] CLRM_2BPP  = 2'd0;
    localparam logic [1:0] CLRM_4BPP  = 2'd1;
    localparam logic [1:0] CLRM_8BPP  = 2'd2;
    localparam logic [1:0] CLRM_16BPP = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_MERGE,
        ST_WR,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [4:0]  lsb;    // bit position of the pixel field in the word
        logic [15:0] pmask;  // right-aligned mask, bpp ones
    } field_t;

    // For bpp < 8 the leftmost pixel sits in the MSBs of its byte, so the
    // sub-byte offset counts down: 2bpp -> 2*(3-sub), 4bpp -> 4*(1-sub).
    // Inverting the sub-index bits yields exactly that offset.
    function automatic field_t field_geom(input logic [1:0] clrm,
                                          input logic [3:0] xlo);
        field_t f;
        f.lsb   = '0;
        f.pmask = '0;
        case (clrm)
            CLRM_2BPP: begin
                f.lsb   = {xlo[3:2], ~xlo[1:0], 1'b0};
                f.pmask = 16'h0003;
            end
            CLRM_4BPP: begin
                f.lsb   = {xlo[2:1], ~xlo[0], 2'b00};
                f.pmask = 16'h000F;
            end
            CLRM_8BPP: begin
                f.lsb   = {xlo[1:0], 3'b000};
                f.pmask = 16'h00FF;
            end
            default: begin
                f.lsb   = {xlo[0], 4'b0000};
                f.pmask = 16'hFFFF;
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/t9990_blit_pixel_rmw_lane.sv
// ---------------------------------------------------------------------------
// t9990_blit_pixel_lane
// Combinational pixel datapath for one 32-bit VRAM word.
//   word_i   : VRAM word (read data or previously captured word)
//   lsb_i    : field LSB within the word
//   pmask_i  : right-aligned bpp-wide field mask
//   src_i    : source pixel, right-aligned (bits above bpp ignored)
//   wmask_i  : write mask, right-aligned, 1 = bit written
//   pix_o    : extracted pixel, right-aligned, zero-extended
//   merged_o : word with the masked source merged into the field
// ---------------------------------------------------------------------------
module t9990_blit_pixel_lane (
    input  logic [31:0] word_i,
    input  logic [4:0]  lsb_i,
    input  logic [15:0] pmask_i,
    input  logic [15:0] src_i,
    input  logic [15:0] wmask_i,
    output logic [15:0] pix_o,
    output logic [31:0] merged_o
);

    logic [31:0] shifted;
    logic [31:0] s_pos;
    logic [31:0] m_pos;

    assign shifted  = word_i >> lsb_i;
    assign pix_o    = shifted[15:0] & pmask_i;

    // Source and mask are clipped to bpp before shifting so that stray
    // high bits can never spill into neighbouring pixels.
    assign s_pos    = {16'h0000, src_i   & pmask_i} << lsb_i;
    assign m_pos    = {16'h0000, wmask_i & pmask_i} << lsb_i;
    assign merged_o = (word_i & ~m_pos) | (s_pos & m_pos);

endmodule

// File: rtl/t9990_blit_pixel_rmw.sv
// ---------------------------------------------------------------------------
// t9990_blit_pixel_rmw
// Pixel access engine between the blitter sequencer and the VRAM arbiter.
// Read: fetch word, return the addressed pixel right-aligned on rdata_o.
// Write: read-modify-write of the word, merging a masked pixel into place.
//
// Optional feature macro: T9990_BLIT_TP_EN
//   When defined, a write with tp_i=1 whose masked source is all zero skips
//   the memory cycles entirely (IDLE -> DONE). When undefined tp_i is
//   ignored and every write performs the full RMW.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   req_i                   start pulse, sampled only while idle
//   we_i                    0 = pixel read, 1 = pixel write (RMW)
//   clrm_i, xlo_i           colour mode and X[3:0] of the pixel
//   addr_i                  VRAM word address
//   wdata_i, wmask_i, tp_i  source pixel, write mask, transparency request
//   busy_o, done_o          operation in progress / one-cycle completion
//   rdata_o                 extracted pixel (held until the next read)
//   mem_*                   VRAM arbiter port (level requests, 1-cycle ack)
// ---------------------------------------------------------------------------
module t9990_blit_pixel_rmw #(
    parameter int AW = 19,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [1:0]    clrm_i,
    input  logic [3:0]    xlo_i,
    input  logic [AW-1:0] addr_i,
    input  logic [15:0]   wdata_i,
    input  logic [15:0]   wmask_i,
    input  logic          tp_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [15:0]   rdata_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_rd_o,
    output logic          mem_wr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ack_i
);

    import t9990_blit_pixel_rmw_pkg::*;

    state_e        state_q, state_d;

    logic          we_q;
    logic [1:0]    clrm_q;
    logic [3:0]    xlo_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   wdata_q;
    logic [15:0]   wmask_q;
    logic [DW-1:0] old_q;
    logic [15:0]   rdata_q;
    logic [DW-1:0] mem_wdata_q;

    field_t        geo;
    logic [DW-1:0] lane_word;
    logic [15:0]   lane_pix;
    logic [DW-1:0] lane_merged;
    logic          tp_skip;
    logic          accept;

    assign accept = (state_q == ST_IDLE) && req_i;

`ifdef T9990_BLIT_TP_EN
    // Decided from the live inputs in IDLE so the skip costs no extra cycle.
    field_t geo_in;
    assign geo_in  = field_geom(clrm_i, xlo_i);
    assign tp_skip = we_i && tp_i && ((wdata_i & wmask_i & geo_in.pmask) == 16'h0000);
`else
    logic unused_tp;
    assign unused_tp = tp_i;
    assign tp_skip   = 1'b0;
`endif

    // ---------------- datapath ----------------
    assign geo       = field_geom(clrm_q, xlo_q);
    // Extraction works on the word arriving with the ack; the merge works
    // on the word captured at that ack.
    assign lane_word = (state_q == ST_MERGE) ? old_q : mem_rdata_i;

    t9990_blit_pixel_lane u_lane (
        .word_i   (lane_word),
        .lsb_i    (geo.lsb),
        .pmask_i  (geo.pmask),
        .src_i    (wdata_q),
        .wmask_i  (wmask_q),
        .pix_o    (lane_pix),
        .merged_o (lane_merged)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            we_q        <= 1'b0;
            clrm_q      <= '0;
            xlo_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            old_q       <= '0;
            rdata_q     <= '0;
            mem_wdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= we_i;
                clrm_q  <= clrm_i;
                xlo_q   <= xlo_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                wmask_q <= wmask_i;
            end
            if ((state_q == ST_RD) && mem_ack_i) begin
                old_q <= mem_rdata_i;
                if (!we_q) begin
                    rdata_q <= lane_pix;
                end
            end
            if (state_q == ST_MERGE) begin
                mem_wdata_q <= lane_merged;
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d = tp_skip ? ST_DONE : ST_RD;
                end
            end
            ST_RD: begin
                if (mem_ack_i) begin
                    state_d = we_q ? ST_MERGE : ST_DONE;
                end
            end
            ST_MERGE: state_d = ST_WR;
            ST_WR: begin
                if (mem_ack_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_o   = 1'b0;
        done_o   = 1'b0;
        mem_rd_o = 1'b0;
        mem_wr_o = 1'b0;
        case (state_q)
            ST_IDLE:  ;
            ST_RD:    begin busy_o = 1'b1; mem_rd_o = 1'b1; end
            ST_MERGE: busy_o = 1'b1;
            ST_WR:    begin busy_o = 1'b1; mem_wr_o = 1'b1; end
            ST_DONE:  begin busy_o = 1'b1; done_o = 1'b1; end
            default:  ;
        endcase
    end

    assign rdata_o     = rdata_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_t9990_blit_pixel_rmw.sv
// ---------------------------------------------------------------------------
// tb_t9990_blit_pixel_rmw
// Directed, table-driven bench for the pixel RMW engine (default build,
// T9990_BLIT_TP_EN undefined). Inputs are driven and outputs sampled on the
// falling edge; the bench plays the VRAM arbiter with configurable waits.
// ---------------------------------------------------------------------------
module tb_t9990_blit_pixel_rmw;

    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          reset, req, we, tp, mem_ack;
    logic [1:0]    clrm;
    logic [3:0]    xlo;
    logic [AW-1:0] addr;
    logic [15:0]   wdata, wmask, rdata;
    logic          busy, done, mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    t9990_blit_pixel_rmw #(.AW(AW), .DW(32)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_i       (req),
        .we_i        (we),
        .clrm_i      (clrm),
        .xlo_i       (xlo),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .wmask_i     (wmask),
        .tp_i        (tp),
        .busy_o      (busy),
        .done_o      (done),
        .rdata_o     (rdata),
        .mem_addr_o  (mem_addr),
        .mem_rd_o    (mem_rd),
        .mem_wr_o    (mem_wr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack)
    );

    typedef struct {
        logic          we;
        logic          tp;
        logic [1:0]    clrm;
        logic [3:0]    xlo;
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
        logic [15:0]   wmask;
        logic [31:0]   old;
        logic [31:0]   exp;   // expected RDATA (read) or MEM_WDATA (write)
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        we = v.we; tp = v.tp; clrm = v.clrm; xlo = v.xlo;
        addr = v.addr; wdata = v.wdata; wmask = v.wmask;
    endtask

    // Issues one operation and acts as the arbiter until DONE (or timeout).
    task automatic run_op(input vec_t v, input int rdw, input int wrw,
                          output int lat, output logic [31:0] wd,
                          output logic [AW-1:0] ad, output logic ovl);
        int cr;
        int cw;
        lat = -1; wd = '0; ad = '0; ovl = 1'b0; cr = 0; cw = 0;
        @(negedge clk);
        drive(v);
        req = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            req = 1'b0;
            mem_ack = 1'b0;
            if (mem_rd && mem_wr) ovl = 1'b1;
            if (done) begin
                lat = c;
                break;
            end
            if (mem_rd) begin
                ad = mem_addr;
                if (cr == rdw) begin mem_ack = 1'b1; mem_rdata = v.old; end
                else cr++;
            end else if (mem_wr) begin
                wd = mem_wdata;
                if (cw == wrw) mem_ack = 1'b1;
                else cw++;
            end
        end
        mem_ack = 1'b0;
    endtask

    vec_t          vecs [12];
    int            lat;
    logic [31:0]   wd;
    logic [AW-1:0] ad;
    logic          ovl;
    logic [15:0]   last_rd;

    initial begin
        vec_t v;
        int   n_done, n_rd, rd_hi;

        //             we    tp    clrm  xlo    addr       wdata     wmask     old           exp
        vecs[0]  = '{1'b0, 1'b0, 2'd1, 4'd5,  19'h00100, 16'h0000, 16'h0000, 32'h12345678, 32'h00000004};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 4'd15, 19'h7FFFC, 16'h0000, 16'h0000, 32'h12345678, 32'h00000002};
        vecs[2]  = '{1'b0, 1'b0, 2'd2, 4'd6,  19'h00204, 16'h0000, 16'h0000, 32'h12345678, 32'h00000034};
        vecs[3]  = '{1'b0, 1'b0, 2'd3, 4'd1,  19'h40000, 16'h0000, 16'h0000, 32'h12345678, 32'h00001234};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 4'd1,  19'h00010, 16'h0003, 16'hFFFF, 32'h00000000, 32'h00000030};
        vecs[5]  = '{1'b1, 1'b0, 2'd3, 4'd1,  19'h00020, 16'hABCD, 16'h00FF, 32'h11223344, 32'h11CD3344};
        vecs[6]  = '{1'b1, 1'b0, 2'd2, 4'd1,  19'h00024, 16'hFFAB, 16'hFFFF, 32'h11223344, 32'h1122AB44};
        vecs[7]  = '{1'b1, 1'b0, 2'd1, 4'd2,  19'h00028, 16'h0005, 16'h000F, 32'hFFFFFFFF, 32'hFFFF5FFF};
        vecs[8]  = '{1'b1, 1'b0, 2'd1, 4'd3,  19'h0002C, 16'h000A, 16'h0003, 32'h00000000, 32'h00000200};
        vecs[9]  = '{1'b1, 1'b1, 2'd2, 4'd0,  19'h00030, 16'h0000, 16'h00FF, 32'h11223344, 32'h11223300};
        vecs[10] = '{1'b0, 1'b0, 2'd0, 4'd0,  19'h00034, 16'h0000, 16'h0000, 32'h000000C0, 32'h00000003};
        vecs[11] = '{1'b1, 1'b0, 2'd0, 4'd14, 19'h00038, 16'h0001, 16'h0003, 32'hFFFFFFFF, 32'hF7FFFFFF};

        reset = 1'b1; req = 1'b0; we = 1'b0; tp = 1'b0; clrm = '0; xlo = '0;
        addr = '0; wdata = '0; wmask = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst busy",      {31'd0, busy},   32'd0);
        chk("rst done",      {31'd0, done},   32'd0);
        chk("rst rdata",     {16'd0, rdata},  32'd0);
        chk("rst mem_addr",  {13'd0, mem_addr}, 32'd0);
        chk("rst mem_rd",    {31'd0, mem_rd}, 32'd0);
        chk("rst mem_wr",    {31'd0, mem_wr}, 32'd0);
        chk("rst mem_wdata", mem_wdata,       32'd0);
        reset = 1'b0;

        // table-driven reads and writes with varying arbiter waits
        last_rd = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            int rdw;
            int wrw;
            rdw = i % 3;
            wrw = (i + 1) % 3;
            run_op(vecs[i], rdw, wrw, lat, wd, ad, ovl);
            chk($sformatf("v%0d latency", i), lat,
                vecs[i].we ? 4 + rdw + wrw : 2 + rdw);
            chk($sformatf("v%0d mem_addr", i), {13'd0, ad}, {13'd0, vecs[i].addr});
            chk($sformatf("v%0d rd/wr overlap", i), {31'd0, ovl}, 32'd0);
            if (vecs[i].we) begin
                chk($sformatf("v%0d mem_wdata", i), wd, vecs[i].exp);
                chk($sformatf("v%0d rdata hold", i), {16'd0, rdata}, {16'd0, last_rd});
            end else begin
                chk($sformatf("v%0d rdata", i), {16'd0, rdata}, vecs[i].exp);
                last_rd = vecs[i].exp[15:0];
            end
        end

        // ack stall holds MEM_RD, then reset mid-RD drops everything without DONE
        v = vecs[0];
        @(negedge clk);
        drive(v); req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        rd_hi = 0; n_done = 0;
        for (int c = 0; c < 10; c++) begin
            if (mem_rd) rd_hi++;
            if (done) n_done++;
            @(negedge clk);
        end
        chk("stall mem_rd held", rd_hi, 10);
        reset = 1'b1;
        @(negedge clk);
        if (done) n_done++;
        chk("midrst mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("midrst busy",   {31'd0, busy},   32'd0);
        chk("midrst done",   n_done,          0);
        reset = 1'b0;

        // REQ while busy (during WR) is ignored; exactly one DONE
        v = '{1'b1, 1'b0, 2'd2, 4'd2, 19'h00400, 16'h005A, 16'h00FF, 32'hAABBCCDD, 32'hAA5ACCDD};
        begin
            int cw;
            cw = 0; n_done = 0; n_rd = 0; wd = '0; ovl = 1'b0;
            @(negedge clk);
            drive(v); req = 1'b1;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                req = 1'b0; mem_ack = 1'b0;
                if (mem_rd && mem_wr) ovl = 1'b1;
                if (done) n_done++;
                if (mem_rd) begin
                    n_rd++; mem_ack = 1'b1; mem_rdata = v.old;
                end else if (mem_wr) begin
                    wd = mem_wdata;
                    if (cw == 3) mem_ack = 1'b1;
                    else begin
                        cw++;
                        req = 1'b1; we = 1'b0; xlo = 4'd0; wdata = 16'h0000; addr = 19'h7FF00;
                    end
                end
            end
            mem_ack = 1'b0;
            chk("busyreq done count",  n_done, 1);
            chk("busyreq rd count",    n_rd,   1);
            chk("busyreq mem_wdata",   wd,     v.exp);
            chk("busyreq overlap",     {31'd0, ovl}, 32'd0);
        end

        // back-to-back: REQ in DONE cycle ignored, the cycle after accepted
        v = '{1'b0, 1'b0, 2'd3, 4'd0, 19'h00500, 16'h0000, 16'h0000, 32'hCAFEF00D, 32'h0000F00D};
        @(negedge clk);
        drive(v); req = 1'b1;
        @(negedge clk);
        req = 1'b0; mem_ack = 1'b1; mem_rdata = v.old;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b first done", {31'd0, done}, 32'd1);
        xlo = 4'd1; req = 1'b1;
        @(negedge clk);
        chk("b2b ignored busy",  {31'd0, busy},   32'd0);
        chk("b2b ignored rd",    {31'd0, mem_rd}, 32'd0);
        chk("b2b first rdata",   {16'd0, rdata},  32'h0000F00D);
        @(negedge clk);
        req = 1'b0;
        chk("b2b accepted busy", {31'd0, busy},   32'd1);
        chk("b2b accepted rd",   {31'd0, mem_rd}, 32'd1);
        mem_ack = 1'b1; mem_rdata = v.old;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b second done",   {31'd0, done},   32'd1);
        chk("b2b second rdata",  {16'd0, rdata},  32'h0000CAFE);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
